// File: rtl/cache_arb_pkg.sv
// Shared constants for the cache read arbiter: FSM states, owner encoding and read types.
package cache_arb_pkg;

    localparam logic ARB_IDLE = 1'b0;
    localparam logic ARB_BUSY = 1'b1;

    localparam logic OWNER_I = 1'b0;
    localparam logic OWNER_D = 1'b1;

    localparam logic [1:0] RD_TYPE_WORD  = 2'b00;
    localparam logic [1:0] RD_TYPE_LINE  = 2'b01;
    localparam logic [1:0] RD_TYPE_DLINE = 2'b10;

    typedef enum logic {
        StIdle = ARB_IDLE,
        StBusy = ARB_BUSY
    } arb_state_e;

endpackage

// File: rtl/cache_arb_rr2.sv
// Two-way round-robin pick: a lone requester wins, on a tie the side not granted last wins.
module cache_arb_rr2
    import cache_arb_pkg::*;
(
    input  logic i_req_i,
    input  logic i_req_d,
    input  logic i_rr_last,
    output logic o_valid,
    output logic o_winner
);

    always_comb begin
        o_valid  = i_req_i | i_req_d;
        o_winner = OWNER_I;
        if (i_req_i && i_req_d) begin
            o_winner = ~i_rr_last;
        end else if (i_req_d) begin
            o_winner = OWNER_D;
        end
    end

endmodule

// File: rtl/cache_rd_arbiter.sv
// Shares one bridge read channel between I-side and D-side with round-robin grant.
// Define CACHE_ARB_PERF_EN to add saturating grant/conflict performance counters.
module cache_rd_arbiter
    import cache_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 256
`ifdef CACHE_ARB_PERF_EN
    ,
    parameter int unsigned PERF_W = 32
`endif
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              i_rd_req,
    input  logic [1:0]        i_rd_type,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic              i_rd_rdy,
    output logic              i_ret_valid,
    output logic              i_ret_half,
    output logic [DATA_W-1:0] i_ret_data,

    input  logic              d_rd_req,
    input  logic [1:0]        d_rd_type,
    input  logic [ADDR_W-1:0] d_rd_addr,
    output logic              d_rd_rdy,
    output logic              d_ret_valid,
    output logic              d_ret_half,
    output logic [DATA_W-1:0] d_ret_data,

    output logic              axi_rd_req,
    output logic [1:0]        axi_rd_type,
    output logic [ADDR_W-1:0] axi_rd_addr,
    input  logic              axi_rd_rdy,
    input  logic              axi_ret_valid,
    input  logic              axi_ret_half,
    input  logic [DATA_W-1:0] axi_ret_data,

    output logic              arb_busy
`ifdef CACHE_ARB_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_i_grant,
    output logic [PERF_W-1:0] perf_d_grant,
    output logic [PERF_W-1:0] perf_conflict
`endif
);

    arb_state_e r_state;
    arb_state_e w_state_next;
    logic       r_owner;
    logic       r_rr_last;
    logic       w_valid;
    logic       w_winner;
    logic       w_hs;

    cache_arb_rr2 u_rr2 (
        .i_req_i   (i_rd_req),
        .i_req_d   (d_rd_req),
        .i_rr_last (r_rr_last),
        .o_valid   (w_valid),
        .o_winner  (w_winner)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= StIdle;
            r_owner   <= OWNER_I;
            r_rr_last <= OWNER_D;
        end else begin
            r_state <= w_state_next;
            if (w_hs) begin
                r_owner   <= w_winner;
                r_rr_last <= w_winner;
            end
        end
    end

    // Every output is forced low while reset is high, even if state is still BUSY.
    always_comb begin
        w_state_next = r_state;
        w_hs         = 1'b0;
        axi_rd_req   = 1'b0;
        axi_rd_type  = '0;
        axi_rd_addr  = '0;
        i_rd_rdy     = 1'b0;
        d_rd_rdy     = 1'b0;
        i_ret_valid  = 1'b0;
        i_ret_half   = 1'b0;
        i_ret_data   = '0;
        d_ret_valid  = 1'b0;
        d_ret_half   = 1'b0;
        d_ret_data   = '0;
        arb_busy     = 1'b0;
        if (!reset) begin
            case (r_state)
                StIdle: begin
                    if (w_valid) begin
                        axi_rd_req = 1'b1;
                        w_hs       = axi_rd_rdy;
                        if (w_winner == OWNER_D) begin
                            axi_rd_type = d_rd_type;
                            axi_rd_addr = d_rd_addr;
                            d_rd_rdy    = axi_rd_rdy;
                        end else begin
                            axi_rd_type = i_rd_type;
                            axi_rd_addr = i_rd_addr;
                            i_rd_rdy    = axi_rd_rdy;
                        end
                        if (w_hs) begin
                            w_state_next = StBusy;
                        end
                    end
                end
                StBusy: begin
                    arb_busy = 1'b1;
                    if (r_owner == OWNER_D) begin
                        d_ret_valid = axi_ret_valid;
                        d_ret_half  = axi_ret_half;
                        d_ret_data  = axi_ret_data;
                    end else begin
                        i_ret_valid = axi_ret_valid;
                        i_ret_half  = axi_ret_half;
                        i_ret_data  = axi_ret_data;
                    end
                    if (axi_ret_valid) begin
                        w_state_next = StIdle;
                    end
                end
                default: w_state_next = StIdle;
            endcase
        end
    end

`ifdef CACHE_ARB_PERF_EN
    logic [PERF_W-1:0] r_perf_i;
    logic [PERF_W-1:0] r_perf_d;
    logic [PERF_W-1:0] r_perf_c;
    logic              w_conflict;

    assign w_conflict = (r_state == StIdle) && i_rd_req && d_rd_req;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_i <= '0;
            r_perf_d <= '0;
            r_perf_c <= '0;
        end else begin
            if (w_hs && (w_winner == OWNER_I) && (r_perf_i != '1)) begin
                r_perf_i <= r_perf_i + PERF_W'(1);
            end
            if (w_hs && (w_winner == OWNER_D) && (r_perf_d != '1)) begin
                r_perf_d <= r_perf_d + PERF_W'(1);
            end
            if (w_conflict && (r_perf_c != '1)) begin
                r_perf_c <= r_perf_c + PERF_W'(1);
            end
        end
    end

    assign perf_i_grant  = reset ? '0 : r_perf_i;
    assign perf_d_grant  = reset ? '0 : r_perf_d;
    assign perf_conflict = reset ? '0 : r_perf_c;
`endif

endmodule
